// File: rtl/ps2_pkg.sv
// State codes and PS/2 protocol bytes shared by the mouse
// bring-up sequencer and its timeout counter.
package ps2_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE     = 4'd0;
   localparam state_t ST_SEND     = 4'd1;
   localparam state_t ST_WAIT_TX  = 4'd2;
   localparam state_t ST_WAIT_ACK = 4'd3;
   localparam state_t ST_WAIT_BAT = 4'd4;
   localparam state_t ST_WAIT_ID  = 4'd5;
   localparam state_t ST_RETRY    = 4'd6;
   localparam state_t ST_RUN      = 4'd7;
   localparam state_t ST_FAIL     = 4'd8;

   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_ERR      = 8'hFC;
   localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
   localparam logic [7:0] PS2_ID_MOUSE = 8'h00;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_RATE     = 8'hF3;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;

   function automatic logic [7:0] cmd_byte(
      input logic [1:0] idx,
      input logic [7:0] rate
   );
      logic [7:0] b;
      unique case (idx)
         2'd0:    b = CMD_RESET;
         2'd1:    b = CMD_RATE;
         2'd2:    b = rate;
         default: b = CMD_ENABLE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Loadable saturating down-counter; expire_o is high while enabled
// and the count has run out.
module ps2_timeout #(
   parameter int unsigned TIMEOUT_CYC = 20000000
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W =
      (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYC - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q <= LOAD_VAL;
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (en_i && cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse bring-up: reset, BAT/ID check, rate set, enable, then
// stream bytes are forwarded to the packet decoder.
module ps2_mouse_init_seq
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 20000000,
   parameter int unsigned MAX_RETRY   = 3,
   parameter logic [7:0]  SAMPLE_RATE = 8'd100,
   parameter bit          HOTPLUG     = 1'b1
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       start_i,
   output logic       tx_valid_o,
   output logic [7:0] tx_data_o,
   input  logic       tx_ready_i,
   input  logic       tx_done_i,
   input  logic       tx_err_i,
   input  logic       rx_valid_i,
   input  logic [7:0] rx_data_i,
   output logic       fwd_valid_o,
   output logic [7:0] fwd_data_o,
   output logic       run_o,
   output logic       fail_o,
   output logic [1:0] retry_cnt_o
);

   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] resend_q, resend_d;
   logic [1:0] retry_q, retry_d;

   logic       in_wait;
   logic       tmo_load;
   logic       tmo_exp;

   logic       run_rx;
   logic       hp_hit;
   logic       aa_seen_q;
   logic       hp_pend_q;
   logic       fwd_valid_q;
   logic [7:0] fwd_data_q;

   assign in_wait = (state_q == ST_WAIT_TX)  ||
                    (state_q == ST_WAIT_ACK) ||
                    (state_q == ST_WAIT_BAT) ||
                    (state_q == ST_WAIT_ID);

   // Restart the timeout on every state change and every received byte.
   assign tmo_load = (state_d != state_q) || rx_valid_i || !in_wait;

   ps2_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tmo (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .load_i   (tmo_load),
      .en_i     (in_wait),
      .expire_o (tmo_exp)
   );

   assign run_rx = (state_q == ST_RUN) && rx_valid_i;
   assign hp_hit = HOTPLUG && run_rx && !hp_pend_q && aa_seen_q &&
                   (rx_data_i == PS2_ID_MOUSE);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      resend_d = resend_q;
      retry_d  = retry_q;
      if (start_i) begin
         state_d  = ST_SEND;
         idx_d    = 2'd0;
         resend_d = 2'd0;
         retry_d  = 2'd0;
      end else if (tmo_exp) begin
         state_d = ST_RETRY;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d  = ST_SEND;
               idx_d    = 2'd0;
               resend_d = 2'd0;
            end
            ST_SEND: begin
               if (tx_ready_i) state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (tx_done_i)     state_d = ST_WAIT_ACK;
               else if (tx_err_i) state_d = ST_RETRY;
            end
            ST_WAIT_ACK: begin
               if (rx_valid_i) begin
                  if (rx_data_i == PS2_ACK) begin
                     resend_d = 2'd0;
                     if (idx_q == 2'd0) begin
                        state_d = ST_WAIT_BAT;
                     end else if (idx_q == 2'd3) begin
                        state_d = ST_RUN;
                     end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                     end
                  end else if (rx_data_i == PS2_RESEND) begin
                     if (resend_q == 2'd2) begin
                        state_d = ST_RETRY;
                     end else begin
                        resend_d = resend_q + 2'd1;
                        state_d  = ST_SEND;
                     end
                  end else begin
                     state_d = ST_RETRY;
                  end
               end
            end
            ST_WAIT_BAT: begin
               if (rx_valid_i) begin
                  if (rx_data_i == PS2_BAT_OK)   state_d = ST_WAIT_ID;
                  else if (rx_data_i == PS2_ERR) state_d = ST_RETRY;
               end
            end
            ST_WAIT_ID: begin
               if (rx_valid_i) begin
                  if (rx_data_i == PS2_ID_MOUSE) begin
                     idx_d   = 2'd1;
                     state_d = ST_SEND;
                  end else begin
                     state_d = ST_RETRY;
                  end
               end
            end
            ST_RETRY: begin
               resend_d = 2'd0;
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 2'd1;
                  idx_d   = 2'd0;
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_FAIL;
               end
            end
            ST_RUN: begin
               if (hp_pend_q) begin
                  state_d  = ST_SEND;
                  idx_d    = 2'd0;
                  resend_d = 2'd0;
                  retry_d  = 2'd0;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         resend_q <= 2'd0;
         retry_q  <= 2'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         resend_q <= resend_d;
         retry_q  <= retry_d;
      end
   end

   // Stream path: forward, and watch for an unsolicited BAT + ID.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         fwd_valid_q <= 1'b0;
         fwd_data_q  <= 8'h00;
         aa_seen_q   <= 1'b0;
         hp_pend_q   <= 1'b0;
      end else begin
         fwd_valid_q <= run_rx;
         if (run_rx) fwd_data_q <= rx_data_i;
         hp_pend_q <= hp_hit && !start_i;
         if (state_q != ST_RUN || start_i) begin
            aa_seen_q <= 1'b0;
         end else if (run_rx) begin
            aa_seen_q <= (rx_data_i == PS2_BAT_OK);
         end
      end
   end

   assign tx_valid_o  = (state_q == ST_SEND);
   assign tx_data_o   = tx_valid_o ? cmd_byte(idx_q, SAMPLE_RATE) : 8'h00;
   assign fwd_valid_o = fwd_valid_q;
   assign fwd_data_o  = fwd_data_q;
   assign run_o       = (state_q == ST_RUN);
   assign fail_o      = (state_q == ST_FAIL);
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Scenario bench for ps2_mouse_init_seq: a scripted mouse model answers
// the host and expected bytes come from the command list.
module tb_ps2_mouse_init_seq;

   localparam int         TMO  = 100;
   localparam logic [7:0] RATE = 8'd100;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic       start_i;
   logic       tx_valid_o;
   logic [7:0] tx_data_o;
   logic       tx_ready_i;
   logic       tx_done_i;
   logic       tx_err_i;
   logic       rx_valid_i;
   logic [7:0] rx_data_i;
   logic       fwd_valid_o;
   logic [7:0] fwd_data_o;
   logic       run_o;
   logic       fail_o;
   logic [1:0] retry_cnt_o;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] cmds [4];
   logic [7:0] exp_q [$];

   always #5 clk_i = ~clk_i;

   ps2_mouse_init_seq #(
      .TIMEOUT_CYC (TMO),
      .MAX_RETRY   (3),
      .SAMPLE_RATE (RATE),
      .HOTPLUG     (1'b1)
   ) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .start_i     (start_i),
      .tx_valid_o  (tx_valid_o),
      .tx_data_o   (tx_data_o),
      .tx_ready_i  (tx_ready_i),
      .tx_done_i   (tx_done_i),
      .tx_err_i    (tx_err_i),
      .rx_valid_i  (rx_valid_i),
      .rx_data_i   (rx_data_i),
      .fwd_valid_o (fwd_valid_o),
      .fwd_data_o  (fwd_data_o),
      .run_o       (run_o),
      .fail_o      (fail_o),
      .retry_cnt_o (retry_cnt_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic get_tx(output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (tx_valid_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) begin
         gap();
         b = tx_data_o;
         tx_ready_i = 1'b1;
         tick();
         tx_ready_i = 1'b0;
      end
   endtask

   task automatic done_pulse();
      gap();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
   endtask

   task automatic err_pulse();
      tx_err_i = 1'b1;
      tick();
      tx_err_i = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] d);
      rx_valid_i = 1'b1;
      rx_data_i  = d;
      tick();
      rx_valid_i = 1'b0;
   endtask

   task automatic start_pulse();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Accept one command; a stray ACK during the frame must be ignored.
   task automatic cmd_stage(input int i, input bit do_done, input string tag);
      logic [7:0] b;
      bit ok;
      get_tx(b, ok);
      n_chk++;
      if (!ok || b !== cmds[i]) begin
         n_fail++;
         $display("FAIL %s_tx%0d: got %02h (offered=%0d) want %02h",
                  tag, i, b, ok, cmds[i]);
      end
      if (do_done) begin
         if ($urandom_range(0, 1) == 1) rx_byte(8'hFA);
         done_pulse();
      end
   endtask

   task automatic bring_up(input string tag);
      logic [7:0] junk;
      for (int i = 0; i < 4; i++) begin
         cmd_stage(i, 1'b1, tag);
         gap();
         rx_byte(8'hFA);
         if (i == 0) begin
            gap();
            junk = 8'($urandom);
            if (junk == 8'hAA || junk == 8'hFC) junk = 8'h3C;
            rx_byte(junk);
            gap();
            rx_byte(8'hAA);
            gap();
            rx_byte(8'h00);
         end
      end
      n_chk++;
      if (run_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_run: run_o=%b want 1", tag, run_o);
      end
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      repeat (3) tick();
      n_chk++;
      if ({tx_valid_o, tx_data_o, fwd_valid_o, fwd_data_o,
           run_o, fail_o, retry_cnt_o} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: tx=%b/%02h fwd=%b/%02h run=%b fail=%b retry=%0d want all 0",
                  tx_valid_o, tx_data_o, fwd_valid_o, fwd_data_o,
                  run_o, fail_o, retry_cnt_o);
      end
      rstn_i = 1'b1;
      tick();
      n_chk++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_first_send: tx=%b/%02h want 1/ff",
                  tx_valid_o, tx_data_o);
      end
   endtask

   task automatic test_healthy();
      logic [7:0] b, prev, e;
      bring_up("healthy");
      n_chk++;
      if (retry_cnt_o !== 2'd0 || fail_o !== 1'b0) begin
         n_fail++;
         $display("FAIL healthy_status: retry=%0d fail=%b want 0/0",
                  retry_cnt_o, fail_o);
      end
      prev = 8'h00;
      for (int k = 0; k < 24; k++) begin
         b = (k == 0) ? 8'h08 : 8'($urandom);
         if (prev == 8'hAA && b == 8'h00) b = 8'h01;
         prev = b;
         exp_q.push_back(b);
         rx_byte(b);
         e = exp_q.pop_front();
         n_chk++;
         if (fwd_valid_o !== 1'b1 || fwd_data_o !== e) begin
            n_fail++;
            $display("FAIL healthy_fwd%0d: got %b/%02h want 1/%02h",
                     k, fwd_valid_o, fwd_data_o, e);
         end
         tick();
         n_chk++;
         if (fwd_valid_o !== 1'b0 || run_o !== 1'b1) begin
            n_fail++;
            $display("FAIL healthy_idle%0d: fwd=%b run=%b want 0/1",
                     k, fwd_valid_o, run_o);
         end
         gap();
      end
   endtask

   task automatic test_resend();
      start_pulse();
      cmd_stage(0, 1'b1, "resend");
      rx_byte(8'hFA);
      rx_byte(8'hAA);
      rx_byte(8'h00);
      cmd_stage(1, 1'b1, "resend");
      rx_byte(8'hFE);
      cmd_stage(1, 1'b1, "resend_again");
      rx_byte(8'hFA);
      for (int i = 2; i < 4; i++) begin
         cmd_stage(i, 1'b1, "resend");
         rx_byte(8'hFA);
      end
      n_chk++;
      if (run_o !== 1'b1 || retry_cnt_o !== 2'd0) begin
         n_fail++;
         $display("FAIL resend_single: run=%b retry=%0d want 1/0",
                  run_o, retry_cnt_o);
      end
      start_pulse();
      cmd_stage(0, 1'b1, "resend3");
      rx_byte(8'hFA);
      rx_byte(8'hAA);
      rx_byte(8'h00);
      for (int r = 0; r < 3; r++) begin
         cmd_stage(1, 1'b1, "resend3");
         rx_byte(8'hFE);
      end
      cmd_stage(0, 1'b0, "resend3_restart");
      n_chk++;
      if (retry_cnt_o !== 2'd1) begin
         n_fail++;
         $display("FAIL resend3_retry: retry=%0d want 1", retry_cnt_o);
      end
   endtask

   task automatic test_silent();
      int  cyc;
      bit  saw;
      start_pulse();
      for (int r = 0; r <= 3; r++) begin
         n_chk++;
         if (retry_cnt_o !== 2'(r)) begin
            n_fail++;
            $display("FAIL silent_retry%0d: retry=%0d want %0d",
                     r, retry_cnt_o, r);
         end
         cmd_stage(0, 1'b1, "silent");
         cyc = 0;
         while (!tx_valid_o && !fail_o && cyc < 400) begin
            tick();
            cyc++;
         end
         // TMO cycles of waiting plus one cycle in RETRY.
         n_chk++;
         if (cyc != TMO + 1) begin
            n_fail++;
            $display("FAIL silent_gap%0d: %0d cycles want %0d",
                     r, cyc, TMO + 1);
         end
      end
      n_chk++;
      if (fail_o !== 1'b1 || retry_cnt_o !== 2'd3) begin
         n_fail++;
         $display("FAIL silent_fail: fail=%b retry=%0d want 1/3",
                  fail_o, retry_cnt_o);
      end
      saw = 1'b0;
      repeat (3 * TMO) begin
         if (tx_valid_o || !fail_o) saw = 1'b1;
         tick();
      end
      n_chk++;
      if (saw) begin
         n_fail++;
         $display("FAIL silent_stuck: left FAIL or offered tx want stay");
      end
      start_pulse();
      n_chk++;
      if (fail_o !== 1'b0 || retry_cnt_o !== 2'd0 ||
          tx_valid_o !== 1'b1 || tx_data_o !== 8'hFF) begin
         n_fail++;
         $display("FAIL silent_start: fail=%b retry=%0d tx=%b/%02h want 0/0/1/ff",
                  fail_o, retry_cnt_o, tx_valid_o, tx_data_o);
      end
   endtask

   task automatic test_tx_err();
      start_pulse();
      cmd_stage(0, 1'b1, "txerr");
      rx_byte(8'hFA);
      rx_byte(8'hAA);
      rx_byte(8'h00);
      for (int i = 1; i < 3; i++) begin
         cmd_stage(i, 1'b1, "txerr");
         rx_byte(8'hFA);
      end
      cmd_stage(3, 1'b0, "txerr");
      gap();
      err_pulse();
      cmd_stage(0, 1'b0, "txerr_restart");
      n_chk++;
      if (retry_cnt_o !== 2'd1 || run_o !== 1'b0) begin
         n_fail++;
         $display("FAIL txerr_retry: retry=%0d run=%b want 1/0",
                  retry_cnt_o, run_o);
      end
   endtask

   task automatic test_hotplug();
      start_pulse();
      cmd_stage(0, 1'b0, "hp_pre");
      err_pulse();
      bring_up("hp");
      n_chk++;
      if (retry_cnt_o !== 2'd1) begin
         n_fail++;
         $display("FAIL hp_retry_kept: retry=%0d want 1", retry_cnt_o);
      end
      rx_byte(8'hAA);
      n_chk++;
      if (fwd_valid_o !== 1'b1 || fwd_data_o !== 8'hAA) begin
         n_fail++;
         $display("FAIL hp_fwd_aa: got %b/%02h want 1/aa",
                  fwd_valid_o, fwd_data_o);
      end
      rx_byte(8'h00);
      n_chk++;
      if (fwd_valid_o !== 1'b1 || fwd_data_o !== 8'h00) begin
         n_fail++;
         $display("FAIL hp_fwd_00: got %b/%02h want 1/00",
                  fwd_valid_o, fwd_data_o);
      end
      tick();
      n_chk++;
      if (run_o !== 1'b0 || tx_valid_o !== 1'b1 ||
          tx_data_o !== 8'hFF || retry_cnt_o !== 2'd0) begin
         n_fail++;
         $display("FAIL hp_restart: run=%b tx=%b/%02h retry=%0d want 0/1/ff/0",
                  run_o, tx_valid_o, tx_data_o, retry_cnt_o);
      end
      bring_up("hp_again");
      rx_byte(8'hAA);
      rx_byte(8'h08);
      n_chk++;
      if (fwd_valid_o !== 1'b1 || fwd_data_o !== 8'h08) begin
         n_fail++;
         $display("FAIL hp_fwd_08: got %b/%02h want 1/08",
                  fwd_valid_o, fwd_data_o);
      end
      repeat (4) tick();
      n_chk++;
      if (run_o !== 1'b1 || tx_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL hp_no_restart: run=%b tx=%b want 1/0",
                  run_o, tx_valid_o);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] b;
      bit ok;
      start_pulse();
      cmd_stage(0, 1'b0, "mr_pre");
      err_pulse();
      cmd_stage(0, 1'b1, "mr");
      rx_byte(8'hFA);
      gap();
      rstn_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      n_chk++;
      if ({tx_valid_o, tx_data_o, fwd_valid_o, fwd_data_o,
           run_o, fail_o, retry_cnt_o} !== 22'd0) begin
         n_fail++;
         $display("FAIL mr_outputs: tx=%b/%02h fwd=%b/%02h run=%b fail=%b retry=%0d want all 0",
                  tx_valid_o, tx_data_o, fwd_valid_o, fwd_data_o,
                  run_o, fail_o, retry_cnt_o);
      end
      tick();
      n_chk++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hFF ||
          retry_cnt_o !== 2'd0) begin
         n_fail++;
         $display("FAIL mr_resend: tx=%b/%02h retry=%0d want 1/ff/0",
                  tx_valid_o, tx_data_o, retry_cnt_o);
      end
      cmd_stage(0, 1'b0, "mr_tmo_pre");
      err_pulse();
      get_tx(b, ok);
      // Timer expires in the cycle after TMO-1 further edges.
      repeat (TMO - 1) tick();
      start_pulse();
      n_chk++;
      if (!ok || b !== 8'hFF || retry_cnt_o !== 2'd0 ||
          tx_valid_o !== 1'b1 || tx_data_o !== 8'hFF) begin
         n_fail++;
         $display("FAIL mr_start_vs_tmo: retry=%0d tx=%b/%02h want 0/1/ff",
                  retry_cnt_o, tx_valid_o, tx_data_o);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cmds[0] = 8'hFF;
      cmds[1] = 8'hF3;
      cmds[2] = RATE;
      cmds[3] = 8'hF4;
      rstn_i     = 1'b0;
      start_i    = 1'b0;
      tx_ready_i = 1'b0;
      tx_done_i  = 1'b0;
      tx_err_i   = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      #1;
      test_reset();
      test_healthy();
      test_resend();
      test_silent();
      test_tx_err();
      test_hotplug();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_mouse_init_seq.md
Name: ps2_mouse_init_seq

Overview:
Host-side command sequencer for a PS/2 mouse attached to a byte-level PS/2 host transceiver (open-drain tx/rx core).
- Resets the device and checks the BAT and ID replies.
- Programs the sample rate and enables data reporting.
- After setup, forwards received movement bytes to the packet decoder that feeds the on-screen mouse_x/y/z/btn display.
- Handles RESEND (0xFE), ERROR (0xFC), timeouts, retries and hot-plug (unsolicited 0xAA 0x00).

Parameters:
TIMEOUT_CYC, 20000000, reply/tx-completion timeout in clk_i cycles (500 ms at 40 MHz)
MAX_RETRY, 3, full-sequence restarts allowed before entering FAIL
SAMPLE_RATE, 8'd100, byte sent after the 0xF3 command
HOTPLUG, 1, 1 = restart the sequence on 0xAA then 0x00 received while in RUN

Ports:
clk_i  in  1  pixel/system clock; all logic on its rising edge
rstn_i  in  1  reset, synchronous, active-low
start_i  in  1  single-cycle pulse: restart the sequence from any state
tx_valid_o  out  1  byte offered to the transceiver
tx_data_o  out  8  byte to transmit
tx_ready_i  in  1  transceiver accepts a byte when tx_valid_o & tx_ready_i
tx_done_i  in  1  pulse: device acknowledged the host frame
tx_err_i  in  1  pulse: host frame aborted (no device clock / bad ack bit)
rx_valid_i  in  1  pulse: rx_data_i holds a received byte with good parity
rx_data_i  in  8  received byte
fwd_valid_o  out  1  movement byte forwarded to the decoder (RUN only)
fwd_data_o  out  8  forwarded byte
run_o  out  1  device configured and streaming
fail_o  out  1  retries exhausted
retry_cnt_o  out  2  full-sequence restarts used in the current attempt

Behaviour:
- Reset (rstn_i=0 at a clock edge) forces all outputs to 0 and state to IDLE; the timeout counter and retry counter clear. The first cycle after reset leaves IDLE for SEND with cmd=0xFF.
- Command list, indexed 0..3: {0xFF, 0xF3, SAMPLE_RATE, 0xF4}. Each command expects 0xFA (ACK). After index 0's ACK, the block also expects 0xAA and then 0x00.
- States:
  - IDLE: go to SEND with index 0.
  - SEND: tx_valid_o=1, tx_data_o=cmd[index]. Holds until tx_ready_i; the handshake cycle moves to WAIT_TX. tx_valid_o deasserts the following cycle.
  - WAIT_TX: tx_done_i goes to WAIT_ACK. tx_err_i goes to RETRY.
  - WAIT_ACK, on rx_valid_i:
    - 0xFA: index 0 goes to WAIT_BAT; index 3 goes to RUN; otherwise index+1 and SEND.
    - 0xFE: back to SEND with the same index. Does not count as a retry. At most 2 consecutive resends, the third goes to RETRY.
    - 0xFC or any other byte: go to RETRY.
  - WAIT_BAT: 0xAA goes to WAIT_ID; 0xFC goes to RETRY; other bytes are ignored.
  - WAIT_ID: 0x00 sets index 1 and goes to SEND; any other byte goes to RETRY.
  - RETRY:
    - retry_cnt < MAX_RETRY: retry_cnt+1, index 0, SEND.
    - otherwise: go to FAIL.
  - RUN: run_o=1. Every rx_valid_i produces fwd_valid_o=1 with fwd_data_o=rx_data_i, registered, one cycle latency.
    - Hot-plug (HOTPLUG=1): a 2-byte detector matches 0xAA immediately followed by 0x00. Both bytes are still forwarded. On the match, the cycle after the 0x00 forward clears run_o, sets retry_cnt to 0, and goes to SEND with index 0.
  - FAIL: fail_o=1. Only start_i or reset leaves this state.
- Timeout:
  - The counter runs in WAIT_TX, WAIT_ACK, WAIT_BAT and WAIT_ID.
  - It clears on every state entry and on every rx_valid_i.
  - Reaching TIMEOUT_CYC-1 goes to RETRY. It never runs in SEND, RUN or FAIL.
- Simultaneous events:
  - Priority order: rstn_i low, then start_i, then timeout, then rx/tx events.
  - start_i clears retry_cnt, fail_o and run_o, and goes to SEND with index 0.
  - rx_valid_i while in SEND or WAIT_TX is discarded, and is not forwarded.
  - The timeout counter is sized $clog2(TIMEOUT_CYC) and saturates; it never wraps.

Decomposition:
- Package ps2_pkg holds:
  - State enum: IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, RETRY, RUN, FAIL.
  - Constants: PS2_ACK=0xFA, PS2_RESEND=0xFE, PS2_ERR=0xFC, PS2_BAT_OK=0xAA, PS2_ID_MOUSE=0x00, CMD_RESET=0xFF, CMD_RATE=0xF3, CMD_ENABLE=0xF4.
- One sub-module, ps2_timeout: a loadable down-counter with clear and an expire pulse.

Test Plan:
1. Healthy device: model answers FA, AA, 00, FA, FA, FA. Required: tx bytes FF, F3, 64, F4 in order, then run_o=1 with retry_cnt_o=0. A following rx 08 gives fwd_data_o=08 one cycle later.
2. Resend: the first reply to F3 is FE. Required: F3 is retransmitted, the sequence completes, and retry_cnt_o stays 0. Three consecutive FE replies give retry_cnt_o=1 and FF is resent.
3. Silent device: tx_done_i arrives but no rx ever follows. Required: a timeout every TIMEOUT_CYC cycles (test with TIMEOUT_CYC=100), retry_cnt_o counts 1, 2, 3, then fail_o=1 and tx_valid_o stays 0 from then on. A start_i pulse clears fail_o and retry_cnt_o and resends FF.
4. tx_err_i pulse in WAIT_TX on the 0xF4 command -> RETRY, retry_cnt_o=1, the sequence restarts at FF.
5. Hot-plug: in RUN, rx AA, 00. Required: both bytes forwarded, then run_o=0 and FF transmitted. rx AA, 08 does not restart.
6. Reset mid-operation: rstn_i low for 1 cycle while in WAIT_BAT. Required: all outputs 0 the next cycle, then FF is resent with retry_cnt_o=0. start_i asserted in the same cycle as a timeout: start wins and retry_cnt_o=0.
